// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: two-stage lane-parallel ALU with per-lane accumulator and sticky compare flags.
module vec_alu_pipe #(
   parameter int WIDTH = 16,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             op,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] result,
   output logic [LANES-1:0]       zero_flags,
   output logic [LANES-1:0]       neg_flags
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [SW:0] WL = (SW+1)'(WIDTH);
   logic s1_valid, s2_valid, s2_open, adv;
   logic [3:0] s1_op;
   logic [LANES*WIDTH-1:0] s1_a, s1_b, nxt;
   assign s2_open = !s2_valid || out_ready;
   assign adv = s1_valid && s2_open && !flush;
   assign in_ready = !s1_valid || s2_open;
   assign out_valid = s2_valid;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         result <= '0;
         s1_op <= '0;
         s1_a <= '0;
         s1_b <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_open) s2_valid <= s1_valid;
         if (adv) result <= nxt;
         if (in_ready) s1_valid <= in_valid;
         if (in_ready && in_valid) begin
            s1_op <= op;
            s1_a <= a;
            s1_b <= b;
         end
      end
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH-1:0] x, y, d, r, acc;
      logic [SW-1:0] s;
      logic zf, nf;
      assign x = s1_a[i*WIDTH +: WIDTH];
      assign y = s1_b[i*WIDTH +: WIDTH];
      assign s = y[SW-1:0];
      assign d = x - y;
      always_comb
         case (s1_op)
            4'd0:        r = x + y;
            4'd1, 4'd10: r = d;
            4'd2:        r = x & y;
            4'd3:        r = x | y;
            4'd4:        r = x ^ y;
            4'd5:        r = ~x;
            4'd6:        r = x << s;
            4'd7:        r = x >> s;
            4'd8:        r = (x << s) | (x >> (WL - {1'b0, s}));
            4'd9:        r = (x >> s) | (x << (WL - {1'b0, s}));
            4'd11:       r = acc + x;
            4'd13:       r = y;
            default:     r = '0;
         endcase
      // ACC/ACLR write their lane result back so a following ACC in S1 sees it next cycle
      always_ff @(posedge clk or negedge rst)
         if (!rst) begin
            acc <= '0;
            zf <= 1'b0;
            nf <= 1'b0;
         end else if (adv) begin
            if (s1_op == 4'd11 || s1_op == 4'd12) acc <= r;
            if (s1_op == 4'd10) begin
               zf <= (x == y);
               nf <= d[WIDTH-1];
            end
         end
      assign nxt[i*WIDTH +: WIDTH] = r;
      assign zero_flags[i] = zf;
      assign neg_flags[i] = nf;
   end
endmodule

// File: tb/tb_vec_alu_pipe.sv
// tb_vec_alu_pipe: scoreboard bench for vec_alu_pipe (WIDTH=16, LANES=4).
module tb_vec_alu_pipe;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid;
   logic [3:0] op = '0;
   logic [63:0] a = '0, b = '0, result;
   logic [3:0] zero_flags, neg_flags;
   logic [63:0] macc = '0;
   typedef struct { logic [63:0] res; logic [63:0] acc_before; } entry_t;
   entry_t q[$];
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   vec_alu_pipe #(.WIDTH(16), .LANES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero_flags(zero_flags), .neg_flags(neg_flags)
   );

   function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      logic [63:0] r = '0;
      for (int i = 0; i < 4; i++) begin
         logic [15:0] p, v, t;
         p = x[i*16 +: 16];
         v = y[i*16 +: 16];
         t = p;
         case (o)
            4'd0:        t = p + v;
            4'd1, 4'd10: t = p - v;
            4'd2:        t = p & v;
            4'd3:        t = p | v;
            4'd4:        t = p ^ v;
            4'd5:        t = ~p;
            4'd6:        t = p << v[3:0];
            4'd7:        t = p >> v[3:0];
            4'd8:        for (int k = 0; k < int'(v[3:0]); k++) t = {t[14:0], t[15]};
            4'd9:        for (int k = 0; k < int'(v[3:0]); k++) t = {t[0], t[15:1]};
            4'd11: begin macc[i*16 +: 16] = macc[i*16 +: 16] + p; t = macc[i*16 +: 16]; end
            4'd12: begin macc[i*16 +: 16] = '0; t = '0; end
            4'd13:       t = v;
            default:     t = '0;
         endcase
         r[i*16 +: 16] = t;
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      entry_t e;
      int k;
      forever begin
         @(negedge clk);
         if (!rst) begin
            q.delete();
            macc = '0;
         end else begin
            if (out_valid && out_ready) begin
               tests++;
               if (q.size() == 0) begin
                  fails++;
                  $display("FAIL scoreboard: unexpected result %h, nothing pending", result);
               end else begin
                  e = q.pop_front();
                  if (result !== e.res) begin
                     fails++;
                     $display("FAIL scoreboard: result %h, want %h", result, e.res);
                  end
               end
            end
            if (flush) begin
               k = int'(out_valid && !out_ready);
               if (q.size() > k) macc = q[k].acc_before;
               q.delete();
            end else if (in_valid && in_ready) begin
               e.acc_before = macc;
               e.res = model(op, a, b);
               q.push_back(e);
            end
         end
      end
   endtask

   task automatic send(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      int n = 0;
      op = o; a = x; b = y; in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         if (n >= 3) out_ready = 1'b1;
         step();
         n++;
      end
      if (n == 50) begin
         tests++; fails++;
         $display("FAIL send_timeout: in_ready %b, want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      tests++; if (result !== 64'h0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
      tests++; if ({zero_flags, neg_flags} !== 8'h00) begin fails++; $display("FAIL reset_flags: got %b want 0", {zero_flags, neg_flags}); end
      step(); step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_rotate_shift();
      out_ready = 1'b1;
      send(4'd8, {4{16'h8001}}, {4{16'h0001}});
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rotl_early: out_valid %b want 0", out_valid); end
      step();
      tests++; if (out_valid !== 1'b1 || result !== {4{16'h0003}}) begin fails++; $display("FAIL rotl: valid %b result %h want 1 %h", out_valid, result, {4{16'h0003}}); end
      send(4'd7, {4{16'hF0F0}}, {4{16'h0013}});
      step();
      tests++; if (result !== {4{16'h1E1E}}) begin fails++; $display("FAIL shr: got %h want %h", result, {4{16'h1E1E}}); end
   endtask

   task automatic test_cmp_flags();
      send(4'd10, {16'h8000, 16'h0000, 16'h0003, 16'h0005}, {16'h0001, 16'h0000, 16'h0004, 16'h0005});
      tests++; if (zero_flags !== 4'b0000) begin fails++; $display("FAIL cmp_early: zero %b want 0000", zero_flags); end
      step();
      tests++; if (zero_flags !== 4'b0101 || neg_flags !== 4'b0010) begin fails++; $display("FAIL cmp_flags: zero %b neg %b want 0101 0010", zero_flags, neg_flags); end
      send(4'd0, {4{16'h0001}}, {4{16'h0002}});
      step();
      tests++; if (zero_flags !== 4'b0101 || neg_flags !== 4'b0010) begin fails++; $display("FAIL add_keeps_flags: zero %b neg %b want 0101 0010", zero_flags, neg_flags); end
   endtask

   task automatic test_acc();
      send(4'd12, 64'h0, 64'h0);
      send(4'd11, {4{16'h0002}}, 64'h0);
      send(4'd11, {4{16'h0003}}, 64'h0);
      send(4'd11, {4{16'hFFFF}}, 64'h0);
      step();
      tests++; if (result !== {4{16'h0004}}) begin fails++; $display("FAIL acc_chain: got %h want %h", result, {4{16'h0004}}); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      step(); step();
      out_ready = 1'b0;
      send(4'd0, {4{16'h0001}}, {4{16'h0001}});
      send(4'd4, {4{16'h00FF}}, {4{16'h0F0F}});
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      for (int n = 0; n < 3; n++) begin
         step();
         tests++; if (out_valid !== 1'b1 || result !== {4{16'h0002}}) begin fails++; $display("FAIL bp_hold: valid %b result %h want 1 %h", out_valid, result, {4{16'h0002}}); end
      end
      out_ready = 1'b1;
      send(4'd13, 64'h0, {4{16'hBEEF}});
      step();
      tests++; if (result !== {4{16'hBEEF}}) begin fails++; $display("FAIL bp_last: got %h want %h", result, {4{16'hBEEF}}); end
   endtask

   task automatic test_flush();
      step(); step();
      send(4'd12, 64'h0, 64'h0);
      send(4'd11, {4{16'h0007}}, 64'h0);
      step(); step();
      out_ready = 1'b0;
      send(4'd10, {4{16'h0009}}, {4{16'h0009}});
      send(4'd11, {4{16'h0005}}, 64'h0);
      tests++; if (zero_flags !== 4'b1111 || neg_flags !== 4'b0000) begin fails++; $display("FAIL flush_pre_flags: zero %b neg %b want 1111 0000", zero_flags, neg_flags); end
      op = 4'd13; b = {4{16'h5A5A}}; in_valid = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_clear: valid %b ready %b want 0 1", out_valid, in_ready); end
      tests++; if (zero_flags !== 4'b1111 || neg_flags !== 4'b0000) begin fails++; $display("FAIL flush_flags: zero %b neg %b want 1111 0000", zero_flags, neg_flags); end
      out_ready = 1'b1;
      send(4'd11, 64'h0, 64'h0);
      step();
      tests++; if (out_valid !== 1'b1 || result !== {4{16'h0007}}) begin fails++; $display("FAIL flush_acc: valid %b result %h want 1 %h", out_valid, result, {4{16'h0007}}); end
   endtask

   task automatic test_reset_midstream();
      step();
      out_ready = 1'b0;
      send(4'd0, {4{16'h0010}}, {4{16'h0001}});
      send(4'd0, {4{16'h0020}}, {4{16'h0001}});
      #2 rst = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_hs: valid %b ready %b want 0 1", out_valid, in_ready); end
      tests++; if (result !== 64'h0 || {zero_flags, neg_flags} !== 8'h00) begin fails++; $display("FAIL rst_mid_state: result %h flags %b want 0 0", result, {zero_flags, neg_flags}); end
      step();
      rst = 1'b1; out_ready = 1'b1;
      send(4'd11, {4{16'h0003}}, 64'h0);
      step();
      tests++; if (out_valid !== 1'b1 || result !== {4{16'h0003}}) begin fails++; $display("FAIL rst_mid_acc: valid %b result %h want 1 %h", out_valid, result, {4{16'h0003}}); end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++) begin
         out_ready = 1'($urandom_range(0, 1));
         send(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
      end
      out_ready = 1'b1;
      repeat (5) step();
      tests++; if (q.size() != 0) begin fails++; $display("FAIL drain: %0d results missing, want 0", q.size()); end
   endtask

   initial begin
      fork monitor(); join_none
      test_reset();
      test_rotate_shift();
      test_cmp_flags();
      test_acc();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vec_alu_pipe.md
VEC_ALU_PIPE -- requirements
Module: vec_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16: lane width in bits; power of two, at least 8.
REQ-002 Parameter LANES, default 4: number of independent lanes; at least 1.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous reset, active-low.
REQ-005 Port in_valid, input, 1: operation and operands presented.
REQ-006 Port in_ready, output, 1: block accepts the operation this cycle.
REQ-007 Port op, input, 4: opcode, as encoded in REQ-013.
REQ-008 Port a and port b, input, LANES*WIDTH each: packed operands; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port flush, input, 1: discards all in-flight operations.
REQ-010 Port out_valid, output, 1: result is available.
REQ-011 Port out_ready, input, 1: consumer takes the result.
REQ-012 Ports result (LANES*WIDTH), zero_flags (LANES) and neg_flags (LANES), all outputs: packed result and sticky per-lane compare flags.

Function
REQ-013 Opcodes, applied per lane:
- 0 ADD: a+b
- 1 SUB: a-b
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT a
- 6 SHL
- 7 SHR (logical)
- 8 ROTL
- 9 ROTR
- 10 CMP: a-b
- 11 ACC: acc+a, result is the new acc
- 12 ACLR: acc=0, result 0
- 13 PASSB: b
- 14 and 15: result 0, no side effects
REQ-014 All arithmetic is modulo 2^WIDTH; carries do not cross lanes.
REQ-015 Shift and rotate amounts equal the low log2(WIDTH) bits of the corresponding b lane; higher b bits are ignored.
REQ-016 Pipeline has two stages:
- S1 registers op, a and b on acceptance (in_valid && in_ready).
- S2 registers the computed result.
REQ-017 Latency: out_valid asserts exactly 2 cycles after the accepting edge when there is no backpressure; throughput is one operation per cycle.
REQ-018 Stall: when out_valid && !out_ready, S2 holds, and S1 holds if it is full.
REQ-019 in_ready = !s1_valid || (S1 advances this cycle); in_ready is combinational from out_ready.
REQ-020 result stays stable while out_valid is high and out_ready is low.
REQ-021 The per-lane accumulator (WIDTH bits, one per lane) updates only on the edge where an ACC or ACLR operation moves from S1 into S2; stalled operations do not update it.
REQ-022 Back-to-back ACC operations see the accumulator value updated by the previous ACC, with no bubble.
REQ-023 zero_flags[i] and neg_flags[i] update only when a CMP operation enters S2:
- zero_flags[i] = (a_i == b_i)
- neg_flags[i] = MSB of (a_i - b_i)
- all other opcodes leave the flags unchanged.
REQ-024 flush (synchronous, priority over everything except rst): clears s1_valid and s2_valid on the next edge, and suppresses any acceptance and any accumulator or flag update in that same cycle.
REQ-025 flush does not clear the accumulator or the flags.
REQ-026 Simultaneous accept and drain: when S2 drains and S1 advances on the same edge, no operation is lost or duplicated.
REQ-027 Zero-output case: out_valid && out_ready with S1 empty leaves out_valid=0 after the edge.

Reset
REQ-028 While rst=0, the following are forced asynchronously to 0: s1_valid, s2_valid, out_valid, result, all accumulators, zero_flags and neg_flags.
REQ-029 While rst=0, in_ready = 1.
REQ-030 Reset mid-operation drops all in-flight operations; the first acceptance after rst rises behaves as from power-on.

Verification (WIDTH=16, LANES=4)
REQ-031 Rotate and shift:
- ROTL with a lanes 0x8001 and b lanes 0x0001 -> result lanes 0x0003, 2 cycles after accept.
- SHR with b=0x0013 uses shift amount 3.
REQ-032 Compare and flags:
- CMP with a={5,3,0,0x8000} and b={5,4,0,1} (lanes 0..3) -> zero_flags=4'b0101, neg_flags=4'b0010.
- A following ADD leaves both flag vectors unchanged.
REQ-033 Accumulator:
- ACLR, then ACC a=2, ACC a=3, ACC a=0xFFFF back-to-back -> results 0, 2, 5, 4 in every lane.
REQ-034 Backpressure:
- Accept ops X, Y, Z on consecutive cycles; hold out_ready=0 for 3 cycles -> in_ready=0 once S1 and S2 are full.
- On release, outputs appear in order X, Y, Z with no loss or duplication.
REQ-035 Flush:
- Assert flush with ACC in S1 and CMP in S2 -> out_valid=0 next cycle.
- Accumulator and flags keep their pre-flush values.
REQ-036 Reset mid-stream:
- Pulse rst low during a stall -> out_valid, accumulators and flags read 0 immediately, and in_ready=1.
